// File: rtl/cpu_phase_sequencer_pkg.sv
// Shared definitions for the CPU phase sequencer: phase encodings and the
// widths used by the sequencer and its MEM-phase wait timer.
package cpu_phase_sequencer_pkg;

  localparam int PHASE_W = 3;
  localparam int TMO_W   = 8;

  // Phase encodings as seen on the phase output.
  typedef enum logic [PHASE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5,
    ST_HALT    = 3'd6,
    ST_BREAK   = 3'd7
  } seq_state_t;

endpackage

// File: rtl/cpu_phase_sequencer_seq_wait_timer.sv
// MEM-phase wait timer: clear/enable counter that flags its terminal count.
// tc is high during the TERMINAL-th enabled cycle after a clear, so a caller
// that leaves the counted phase on tc spends exactly TERMINAL cycles in it.
module cpu_phase_sequencer_seq_wait_timer
  import cpu_phase_sequencer_pkg::*;
#(
  parameter int TERMINAL = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [TMO_W-1:0] TC_VAL = TMO_W'(TERMINAL - 1);

  logic [TMO_W-1:0] count_reg;

  // Count enabled cycles; clear has priority so a completed access restarts at 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign tc = en && (count_reg == TC_VAL);

endmodule

// File: rtl/cpu_phase_sequencer.sv
// Multi-phase execution sequencer for the single-cycle RISC-V datapath.
// Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB, stalls in MEM
// until mem_ready, supports free-run, single-step and halt.
// Optional breakpoint support is compiled in with `define SEQ_BREAKPOINT_EN.
module cpu_phase_sequencer
  import cpu_phase_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 32
) (
  input  logic               clk,
  input  logic               rst,
`ifdef SEQ_BREAKPOINT_EN
  input  logic               bp_en,
  input  logic [31:0]        bp_addr,
  input  logic [31:0]        pc,
  output logic               bp_hit,
`endif
  input  logic               run_mode,
  input  logic               step_req,
  input  logic               halt_req,
  input  logic               mem_access,
  input  logic               mem_ready,
  output logic               if_en,
  output logic               pc_en,
  output logic               rf_we_en,
  output logic               mem_req,
  output logic [PHASE_W-1:0] phase,
  output logic               halted,
  output logic               timeout_err,
  output logic [CNT_W-1:0]   instr_count
);

  seq_state_t       state_reg;
  logic             timeout_err_reg;
  logic [CNT_W-1:0] instr_count_reg;
  logic             tmo_tc;
  seq_state_t       fetch_target;

  // The wait counter only runs in MEM and restarts whenever MEM completes or is left.
  cpu_phase_sequencer_seq_wait_timer #(
    .TERMINAL (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk (clk),
    .rst (rst),
    .clr ((state_reg != ST_MEM) || mem_ready),
    .en  (state_reg == ST_MEM),
    .tc  (tmo_tc)
  );

`ifdef SEQ_BREAKPOINT_EN
  // A new fetch from IDLE or WB is diverted to BREAK when the PC matches.
  assign fetch_target = (bp_en && (pc == bp_addr)) ? ST_BREAK : ST_FETCH;
`else
  assign fetch_target = ST_FETCH;
`endif

  // Phase state machine plus the sticky timeout flag and the retire counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= ST_IDLE;
      timeout_err_reg <= 1'b0;
      instr_count_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (run_mode || step_req) begin
            state_reg <= fetch_target;
          end
        end
        ST_FETCH: begin
          state_reg <= ST_DECODE;
        end
        ST_DECODE: begin
          state_reg <= halt_req ? ST_HALT : ST_EXECUTE;
        end
        ST_EXECUTE: begin
          state_reg <= mem_access ? ST_MEM : ST_WB;
        end
        ST_MEM: begin
          // A completion on the terminal cycle still counts as success.
          if (mem_ready) begin
            state_reg <= ST_WB;
          end else if (tmo_tc) begin
            timeout_err_reg <= 1'b1;
            state_reg       <= ST_HALT;
          end
        end
        ST_WB: begin
          instr_count_reg <= instr_count_reg + 1'b1;
          state_reg       <= run_mode ? fetch_target : ST_IDLE;
        end
        ST_HALT: begin
          state_reg <= ST_HALT;
        end
`ifdef SEQ_BREAKPOINT_EN
        ST_BREAK: begin
          // Stepping out of BREAK goes straight to FETCH, skipping the PC match.
          if (step_req) begin
            state_reg <= ST_FETCH;
          end
        end
`endif
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign phase       = state_reg;
  assign if_en       = (state_reg == ST_FETCH);
  assign pc_en       = (state_reg == ST_WB);
  assign rf_we_en    = (state_reg == ST_WB);
  assign mem_req     = (state_reg == ST_MEM);
  assign halted      = (state_reg == ST_HALT);
  assign timeout_err = timeout_err_reg;
  assign instr_count = instr_count_reg;
`ifdef SEQ_BREAKPOINT_EN
  assign bp_hit      = (state_reg == ST_BREAK);
`endif

endmodule
